fifo_stream_reader: RTL and testbench

- Read-side master for the team's 8-bit synchronous FIFO. It drives the FIFO read enable, captures read data that arrives one cycle after each accepted read, and presents it as a valid/ready byte stream.
- Adds burst framing with a last-beat flag every BURST_LEN beats.
- Sits between the FIFO and downstream consumers (packetiser, UART TX). A 3-entry skid buffer absorbs downstream backpressure without losing in-flight reads.

---
 rtl/fifo_stream_reader.sv | 83 ++++++++
 tb/tb_fifo_stream_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side master for the 8-bit synchronous FIFO.
// Issues FIFO reads and captures the data one cycle later into a
// 3-entry skid buffer. The buffer is presented as a valid/ready byte
// stream, with a last-beat flag every BURST_LEN beats.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   enable            permits new FIFO reads (buffered/in-flight data still drains)
//   fifo_empty        FIFO empty flag
//   fifo_dout         FIFO read data, valid the cycle after an accepted read
//   fifo_rd_en        FIFO read enable (combinational, independent of m_ready)
//   m_valid, m_data   output beat and its data
//   m_ready           downstream accept
//   m_last            final beat of the current burst
//   total_words       wrapping count of accepted beats
//   busy              buffer non-empty or read in flight
module fifo_stream_reader #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              m_last,
    output logic [CNT_W-1:0]  total_words,
    output logic              busy
);
    logic [DATA_W-1:0] mem [0:2];
    logic [1:0]        head;
    logic [1:0]        tail;
    logic [1:0]        buf_cnt;
    logic              inflight;
    logic [7:0]        beat_cnt;
    logic              push;
    logic              pop;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reads in flight count against capacity so every issued read has a slot.
    assign fifo_rd_en = enable && !fifo_empty && !rst &&
                        (({1'b0, buf_cnt} + {2'b00, inflight}) < 3'd3);
    assign push       = inflight;
    assign m_valid    = buf_cnt != 2'd0;
    assign pop        = m_valid && m_ready;
    assign m_data     = mem[head];
    assign m_last     = m_valid && (beat_cnt == 8'(BURST_LEN - 1));
    assign busy       = m_valid || inflight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem         <= '{default: '0};
            head        <= '0;
            tail        <= '0;
            buf_cnt     <= '0;
            inflight    <= 1'b0;
            beat_cnt    <= '0;
            total_words <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (push) begin
                mem[tail] <= fifo_dout;
                tail      <= nxt(tail);
            end
            if (pop) begin
                head        <= nxt(head);
                beat_cnt    <= m_last ? 8'd0 : beat_cnt + 8'd1;
                total_words <= total_words + 1'b1;
            end
            if (push && !pop)
                buf_cnt <= buf_cnt + 2'd1;
            else if (pop && !push)
                buf_cnt <= buf_cnt - 2'd1;
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed checks plus a queue-based stream model for fifo_stream_reader.
module tb_fifo_stream_reader;
    localparam int DW = 8;
    localparam int BL = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic m_ready = 1'b0;
    logic fifo_empty, fifo_rd_en, m_valid, m_last, busy;
    logic [DW-1:0] fifo_dout;
    logic [DW-1:0] m_data;
    logic [CW-1:0] total_words;

    logic [DW-1:0] fmem [4096];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic fire_rd = 1'b0;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pops = 0;
    int rd_pulses = 0;
    int last_cnt = 0;

    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ent_t;
    ent_t oq[$];
    logic [DW-1:0] sent[$];
    logic [DW-1:0] got[$];

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    fifo_stream_reader #(.DATA_W(DW), .BURST_LEN(BL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .m_last(m_last),
        .total_words(total_words), .busy(busy)
    );

    // Bench FIFO: registered read data, flushed by the shared reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= wr_ptr;
            fifo_dout <= '0;
        end else if (fire_rd) begin
            fifo_dout <= fmem[rd_ptr % 4096];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        fmem[wr_ptr % 4096] = d;
        wr_ptr++;
        sent.push_back(d);
    endtask

    task automatic wait_got(input int n, input int lim);
        int k = 0;
        while (got.size() < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("wait_budget", 32'(got.size() >= n), 1);
    endtask

    // Model: a word read from the FIFO in cycle t is offered from cycle t+2
    // until accepted; words outstanding = buffered + in flight.
    always @(negedge clk) begin
        logic ev, er, el;
        cyc++;
        if (rst) begin
            chk("rst_valid", 32'(m_valid), 0);
            chk("rst_last", 32'(m_last), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_rd_en", 32'(fifo_rd_en), 0);
            chk("rst_data", 32'(m_data), 0);
            chk("rst_total", 32'(total_words), 0);
            oq.delete();
            pops = 0;
            fire_rd = 1'b0;
        end else begin
            ev = oq.size() > 0 && oq[0].t <= cyc - 2;
            er = enable && !fifo_empty && oq.size() < 3;
            el = ev && (pops % BL == BL - 1);
            chk("rd_en", 32'(fifo_rd_en), 32'(er));
            chk("rd_while_empty", 32'(fifo_rd_en && fifo_empty), 0);
            chk("valid", 32'(m_valid), 32'(ev));
            chk("last", 32'(m_last), 32'(el));
            chk("busy", 32'(busy), 32'(oq.size() != 0));
            chk("total_words", 32'(total_words), 32'(pops % 256));
            if (ev)
                chk("data", 32'(m_data), 32'(oq[0].d));
            if (ev && m_ready) begin
                got.push_back(m_data);
                if (m_last)
                    last_cnt++;
                void'(oq.pop_front());
                pops++;
            end
            fire_rd = fifo_rd_en && !fifo_empty;
            if (fire_rd) begin
                oq.push_back('{d: fmem[rd_ptr % 4096], t: cyc});
                rd_pulses++;
            end
        end
    end

    initial begin
        int t_rd, t_v, nb, r0, l0, g0, n, e;
        logic [DW-1:0] bd [8];
        int bc [8];
        logic bz [30];
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Preloaded 0x01..0x05, streaming with m_ready high.
        for (int i = 1; i <= 5; i++) push(DW'(i));
        @(posedge clk); #1;
        enable = 1'b1;
        m_ready = 1'b1;
        t_rd = -1; t_v = -1; nb = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            bz[k] = busy;
            if (t_rd < 0 && fifo_rd_en) t_rd = k;
            if (t_v < 0 && m_valid) t_v = k;
            if (m_valid && m_ready && nb < 8) begin
                bd[nb] = m_data;
                bc[nb] = k;
                nb++;
            end
        end
        chk("t1_latency", 32'(t_v - t_rd), 2);
        chk("t1_beats", 32'(nb), 5);
        for (int i = 0; i < 5; i++) chk("t1_data", 32'(bd[i]), 32'(i + 1));
        chk("t1_consecutive", 32'(bc[4] - bc[0]), 4);
        chk("t1_busy_at_last", 32'(bz[bc[4]]), 1);
        chk("t1_busy_after", 32'(bz[bc[4] + 1]), 0);
        chk("t1_total", 32'(total_words), 5);

        // Backpressure and burst framing from a fresh reset.
        enable = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(DW'(8'h10 + i));
        @(posedge clk); #1;
        enable = 1'b1;
        r0 = rd_pulses;
        repeat (8) @(posedge clk);
        #1;
        chk("t2_rd_pulses", 32'(rd_pulses - r0), 3);
        chk("t2_fifo_count", 32'(wr_ptr - rd_ptr), 7);
        chk("t2_hold_data", 32'(m_data), 32'h10);
        chk("t2_hold_valid", 32'(m_valid), 1);
        l0 = last_cnt;
        g0 = got.size();
        m_ready = 1'b1;
        wait_got(g0 + 10, 60);
        repeat (2) @(negedge clk);
        chk("t2_count", 32'(got.size() - g0), 10);
        for (int i = 0; i < 10; i++) chk("t2_order", 32'(got[g0 + i]), 32'(8'h10 + i));
        chk("t2_lasts", 32'(last_cnt - l0), 2);

        // Enable dropped the cycle after an accepted read.
        @(posedge clk); #1;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) push(DW'(8'h30 + i));
        l0 = last_cnt;
        g0 = got.size();
        @(posedge clk); #1;
        enable = 1'b1;
        r0 = rd_pulses;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t3_rd_pulses", 32'(rd_pulses - r0), 1);
        chk("t3_delivered", 32'(got.size() - g0), 1);
        chk("t3_byte", 32'(got[got.size() - 1]), 32'h30);
        chk("t3_fifo_count", 32'(wr_ptr - rd_ptr), 2);
        chk("t3_total", 32'(total_words), 11);
        enable = 1'b1;
        wait_got(g0 + 3, 30);
        repeat (2) @(negedge clk);
        chk("t3_lasts", 32'(last_cnt - l0), 1);
        chk("t3_total_end", 32'(total_words), 13);

        // Random backpressure with concurrent writes; total_words wraps.
        n = 0;
        for (int c = 0; c < 8000 && (n < 1000 || !fifo_empty || busy); c++) begin
            @(posedge clk); #1;
            if (n < 1000 && $urandom_range(1) == 1) begin
                push(DW'($urandom_range(255)));
                n++;
            end
            m_ready = 1'($urandom_range(1));
        end
        m_ready = 1'b1;
        chk("t4_drained", 32'(n == 1000 && fifo_empty && !busy), 1);
        chk("t4_size", 32'(got.size()), 32'(sent.size()));
        e = 0;
        for (int i = 0; i < sent.size() && i < got.size(); i++)
            if (got[i] !== sent[i]) e++;
        chk("t4_order_errors", 32'(e), 0);
        chk("t4_total_wrapped", 32'(total_words), 32'((13 + 1000) % 256));

        // Asynchronous reset with 2 buffered and 1 in flight.
        @(posedge clk); #1;
        enable = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(DW'(8'h50 + i));
        @(posedge clk); #1;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("t5_pre_valid", 32'(m_valid), 1);
        rst = 1'b1;
        #1;
        chk("t5_valid", 32'(m_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_total", 32'(total_words), 0);
        chk("t5_rd_en", 32'(fifo_rd_en), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        push(8'hA1);
        push(8'hA2);
        m_ready = 1'b1;
        g0 = got.size();
        wait_got(g0 + 2, 30);
        repeat (3) @(negedge clk);
        chk("t5_count", 32'(got.size() - g0), 2);
        chk("t5_first", 32'(got[g0]), 32'hA1);
        chk("t5_second", 32'(got[g0 + 1]), 32'hA2);
        chk("t5_total_end", 32'(total_words), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
